// File: rtl/mips_core_pkg.sv
// Shared types for the memory pipeline: LSQ and store-buffer entry layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Entry field widths are fixed here, so instantiating modules must keep their
// ADDR_WIDTH/DATA_WIDTH/TAG_WIDTH equal to ADDR_W/DATA_W/TAG_W.
package mips_core_pkg;

  localparam int LSQ_DEPTH_DEF  = 8;
  localparam int SB_DEPTH_DEF   = 8;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TAG_W          = 4;
  localparam int LSQ_DEPTH_BITS = $clog2(LSQ_DEPTH_DEF);
  localparam int SB_DEPTH_BITS  = $clog2(SB_DEPTH_DEF);

  // While addr_rdy=0, addr holds the sign-extended offset still waiting for its base.
  typedef struct packed {
    logic              valid;
    logic              is_store;
    logic [TAG_W-1:0]  tag;
    logic              addr_rdy;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  addr_tag;
    logic              data_rdy;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  data_tag;
  } lsq_entry_t;

  typedef struct packed {
    logic              valid;
    logic              committed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer.sv
// Store buffer: in-order FIFO of dispatched stores, commit marking, youngest-match search, drain.
// Latency: push visible next cycle; st_req_* is driven combinationally from the registered head entry.
// Backpressure: full blocks push (from registered state only); the head holds on st_req_ready=0.
// Ports: push/push_addr/push_data/full (from LSQ), commit_st, flush, search_addr -> match/match_data,
//        st_req_valid/ready/addr/data (D-cache store channel).
module mem_store_buffer
  import mips_core_pkg::*;
#(
  parameter int SB_DEPTH   = SB_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  commit_st,
  input  logic [ADDR_WIDTH-1:0] search_addr,
  output logic                  match,
  output logic [DATA_WIDTH-1:0] match_data,
  output logic                  st_req_valid,
  input  logic                  st_req_ready,
  output logic [ADDR_WIDTH-1:0] st_req_addr,
  output logic [DATA_WIDTH-1:0] st_req_data
);

  localparam int SW = $clog2(SB_DEPTH);

  sb_entry_t     sb_q [SB_DEPTH];
  logic [SW:0]   head_q, tail_q, cmt_q, cmt_nxt;
  logic [SW-1:0] head_idx, tail_idx, cmt_idx, scan_idx;
  logic          uncmt_any, commit_do, pop, push_ok;

  assign head_idx = head_q[SW-1:0];
  assign tail_idx = tail_q[SW-1:0];
  assign cmt_idx  = cmt_q[SW-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[SW] != tail_q[SW]);

  // cmt_q points at the oldest uncommitted entry; everything from head to cmt_q-1 is committed.
  assign uncmt_any = (cmt_q != tail_q);
  assign commit_do = commit_st && uncmt_any;
  assign cmt_nxt   = commit_do ? cmt_q + 1'b1 : cmt_q;
  assign push_ok   = push && !full && !flush;

  assign st_req_valid = sb_q[head_idx].valid && sb_q[head_idx].committed;
  assign st_req_addr  = st_req_valid ? sb_q[head_idx].addr : '0;
  assign st_req_data  = st_req_valid ? sb_q[head_idx].data : '0;
  assign pop          = st_req_valid && st_req_ready;

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    match      = 1'b0;
    match_data = '0;
    scan_idx   = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx = head_idx + k[SW-1:0];
      if (sb_q[scan_idx].valid && (sb_q[scan_idx].addr == search_addr)) begin
        match      = 1'b1;
        match_data = sb_q[scan_idx].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cmt_q  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
    end else begin
      // A commit in the flush cycle lands first, so that entry survives the truncation.
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (commit_do && (cmt_idx == i[SW-1:0])) begin
          sb_q[i].committed <= 1'b1;
        end else if (flush && sb_q[i].valid && !sb_q[i].committed) begin
          sb_q[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        sb_q[head_idx].valid <= 1'b0;
        head_q               <= head_q + 1'b1;
      end
      if (push_ok) begin
        sb_q[tail_idx] <= {1'b1, 1'b0, push_addr, push_data};
        tail_q         <= tail_q + 1'b1;
      end
      cmt_q <= cmt_nxt;
      if (flush) tail_q <= cmt_nxt;
    end
  end

endmodule

// File: rtl/mem_lsq_fwd.sv
// In-order load/store queue with store buffer and store-to-load forwarding on exact address match.
// Latency: alloc to ld_req_valid or fwd_valid is two cycles with operands ready; store to SB one cycle.
// Backpressure: lsq_full stalls decode; ld_req_* hold until ld_req_ready; a full SB stalls a store head.
// Ports: alloc_* (decode), cdb_* (operand snoop), commit_st/flush (ROB), ld_req_*/st_req_* (D-cache),
//        fwd_* (forwarded load result, one-cycle pulse).
module mem_lsq_fwd
  import mips_core_pkg::*;
#(
  parameter int LSQ_DEPTH  = LSQ_DEPTH_DEF,
  parameter int SB_DEPTH   = SB_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int TAG_WIDTH  = TAG_W,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic                  alloc_is_store,
  input  logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic [ADDR_WIDTH-1:0] alloc_offset,
  input  logic                  alloc_base_rdy,
  input  logic [DATA_WIDTH-1:0] alloc_base,
  input  logic [TAG_WIDTH-1:0]  alloc_base_tag,
  input  logic                  alloc_data_rdy,
  input  logic [DATA_WIDTH-1:0] alloc_data,
  input  logic [TAG_WIDTH-1:0]  alloc_data_tag,
  output logic                  lsq_full,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  commit_st,
  output logic                  ld_req_valid,
  input  logic                  ld_req_ready,
  output logic [ADDR_WIDTH-1:0] ld_req_addr,
  output logic [TAG_WIDTH-1:0]  ld_req_tag,
  output logic                  st_req_valid,
  input  logic                  st_req_ready,
  output logic [ADDR_WIDTH-1:0] st_req_addr,
  output logic [DATA_WIDTH-1:0] st_req_data,
  output logic                  fwd_valid,
  output logic [TAG_WIDTH-1:0]  fwd_tag,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  localparam int LW = $clog2(LSQ_DEPTH);

  lsq_entry_t      lsq_q [LSQ_DEPTH];
  lsq_entry_t      new_e;
  logic [LW:0]     head_q, tail_q;
  logic [LW-1:0]   head_idx, tail_idx;
  logic            lsq_empty, alloc_fire, head_rdy, ld_head, st_head;
  logic            sb_push, sb_full, sb_match;
  logic [DATA_WIDTH-1:0] sb_match_data;
  logic            ld_issue, ld_fwd, ld_accept, lsq_pop;

  assign head_idx   = head_q[LW-1:0];
  assign tail_idx   = tail_q[LW-1:0];
  assign lsq_empty  = (head_q == tail_q);
  assign lsq_full   = (head_idx == tail_idx) && (head_q[LW] != tail_q[LW]);
  assign alloc_fire = alloc_valid && !lsq_full && !flush;

  // Loads are allocated with data_rdy=1, so one test covers both kinds.
  assign head_rdy  = !lsq_empty && lsq_q[head_idx].addr_rdy && lsq_q[head_idx].data_rdy;
  assign st_head   = head_rdy && lsq_q[head_idx].is_store;
  assign ld_head   = head_rdy && !lsq_q[head_idx].is_store;
  assign ld_accept = ld_req_valid && ld_req_ready;

  // A load already presented to the cache owns the head until accepted; it must not re-issue.
  assign sb_push  = st_head && !sb_full && !flush;
  assign ld_fwd   = FWD_EN && ld_head && !ld_req_valid && sb_match && !flush;
  assign ld_issue = ld_head && !ld_req_valid && !sb_match && !flush;
  assign lsq_pop  = sb_push || ld_fwd || ld_accept;

  always_comb begin
    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.is_store = alloc_is_store;
    new_e.tag      = alloc_tag;
    new_e.addr_tag = alloc_base_tag;
    new_e.data_tag = alloc_data_tag;
    if (alloc_base_rdy) begin
      new_e.addr_rdy = 1'b1;
      new_e.addr     = alloc_base + alloc_offset;
    end else if (cdb_valid && (cdb_tag == alloc_base_tag)) begin
      new_e.addr_rdy = 1'b1;
      new_e.addr     = alloc_offset + cdb_data;
    end else begin
      new_e.addr     = alloc_offset;
    end
    if (!alloc_is_store || alloc_data_rdy) begin
      new_e.data_rdy = 1'b1;
      new_e.data     = alloc_data;
    end else if (cdb_valid && (cdb_tag == alloc_data_tag)) begin
      new_e.data_rdy = 1'b1;
      new_e.data     = cdb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < LSQ_DEPTH; i++) lsq_q[i] <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < LSQ_DEPTH; i++) lsq_q[i] <= '0;
    end else begin
      for (int i = 0; i < LSQ_DEPTH; i++) begin
        if (lsq_q[i].valid && !lsq_q[i].addr_rdy && cdb_valid && (cdb_tag == lsq_q[i].addr_tag)) begin
          lsq_q[i].addr     <= lsq_q[i].addr + cdb_data;
          lsq_q[i].addr_rdy <= 1'b1;
        end
        if (lsq_q[i].valid && !lsq_q[i].data_rdy && cdb_valid && (cdb_tag == lsq_q[i].data_tag)) begin
          lsq_q[i].data     <= cdb_data;
          lsq_q[i].data_rdy <= 1'b1;
        end
      end
      if (lsq_pop) begin
        lsq_q[head_idx].valid <= 1'b0;
        head_q                <= head_q + 1'b1;
      end
      if (alloc_fire) begin
        lsq_q[tail_idx] <= new_e;
        tail_q          <= tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_req_valid <= 1'b0;
      ld_req_addr  <= '0;
      ld_req_tag   <= '0;
      fwd_valid    <= 1'b0;
      fwd_tag      <= '0;
      fwd_data     <= '0;
    end else begin
      fwd_valid <= 1'b0;
      if (flush || ld_accept) begin
        ld_req_valid <= 1'b0;
      end else if (ld_issue) begin
        ld_req_valid <= 1'b1;
        ld_req_addr  <= lsq_q[head_idx].addr;
        ld_req_tag   <= lsq_q[head_idx].tag;
      end
      if (ld_fwd) begin
        fwd_valid <= 1'b1;
        fwd_tag   <= lsq_q[head_idx].tag;
        fwd_data  <= sb_match_data;
      end
    end
  end

  mem_store_buffer #(
    .SB_DEPTH   (SB_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (sb_push),
    .push_addr    (lsq_q[head_idx].addr),
    .push_data    (lsq_q[head_idx].data),
    .full         (sb_full),
    .commit_st    (commit_st),
    .search_addr  (lsq_q[head_idx].addr),
    .match        (sb_match),
    .match_data   (sb_match_data),
    .st_req_valid (st_req_valid),
    .st_req_ready (st_req_ready),
    .st_req_addr  (st_req_addr),
    .st_req_data  (st_req_data)
  );

endmodule
